serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled only on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled only on the edge that accepts start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled only on the edge that accepts start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result of A+B+cin.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out of the MSB.

Function
REQ-012 The block SHALL have FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE with start=1, the block SHALL, on the edge, latch a, b and cin, clear the bit counter, and go to RUN (so back-to-back operations are accepted from DONE).
REQ-014 In IDLE or DONE with start=0, the block SHALL go to IDLE (DONE lasts exactly one cycle).
REQ-015 In RUN, the block SHALL, on each edge, add operand bit [count] using one 1-bit full-adder cell, LSB first, store the sum bit, store the carry for the next bit, and increment count.
REQ-016 On the RUN edge with count=WIDTH-1, the block SHALL update sum and cout and go to DONE.
REQ-017 Latency: with the start edge counted as edge 0, done SHALL be high in the cycle after edge WIDTH, and the total cost SHALL be WIDTH+1 cycles per operation.
REQ-018 The block SHALL ignore start while in RUN, and the latched operands SHALL stay unchanged.
REQ-019 sum and cout SHALL hold the last result until the final RUN edge of the next operation; intermediate bits SHALL NOT be visible on sum.
REQ-020 The block SHALL compute sum and cout modulo 2^(WIDTH+1), exactly equal to {cout,sum} = a+b+cin; the counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-021 With WIDTH=1, the block SHALL spend exactly one cycle in RUN.

Reset
REQ-022 While rst_n=0 on an edge, the block SHALL drive state IDLE, count 0, busy 0, done 0, sum 0 and cout 0, and clear the internal carry and operand registers.
REQ-023 A reset asserted mid-RUN SHALL abort the operation with no done pulse; start SHALL be accepted on the first edge after rst_n returns high.

Configuration
REQ-024 When macro SERIAL_ADD_OVF_EN is defined, the block SHALL add output port ovf, 1 bit, giving two's-complement signed overflow (carry into MSB XOR carry out of MSB), reset to 0 and updated and held exactly like cout.
REQ-025 When SERIAL_ADD_OVF_EN is not defined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 The state encoding enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in shared package serial_add_pkg.
REQ-027 The per-bit add SHALL instantiate the team's existing 1-bit full-adder module fa as the only sub-module, with exactly one instance.

Verification
REQ-028 With WIDTH=8, a=0xFF, b=0x01 and cin=0, the bench SHALL check that done pulses 9 cycles after the start edge, with sum=0x00 and cout=1.
REQ-029 With a=0x7F, b=0x01 and cin=0 under SERIAL_ADD_OVF_EN, the bench SHALL check sum=0x80, cout=0 and ovf=1; with a=0x80, b=0x80 it SHALL check sum=0x00, cout=1 and ovf=1.
REQ-030 With a=0x12, b=0x34, cin=1, and start re-asserted with a=0xFF during RUN, the bench SHALL check that the result is sum=0x47, cout=0 and that only one done pulse occurs.
REQ-031 With start held high continuously on a=0x01, b=0x01, the bench SHALL check that done pulses every 9 cycles with sum=0x02, and that busy drops only during the DONE cycle.
REQ-032 With rst_n driven low at RUN count=4, the bench SHALL check that all outputs are 0 on the next edge, that no done pulse occurs, and that a new start then yields a correct result.
REQ-033 With WIDTH=1, a=1, b=1 and cin=1, the bench SHALL check that done pulses 2 cycles after the start edge with sum=1 and cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// 1-bit full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, WIDTH+1 cycles per add.
// Optional signed-overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_reg;
`endif

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] work_next;
  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             bit_co;

  // One-hot select of the current bit avoids a variable part-select on the operands.
  assign bit_mask  = WIDTH'(1) << count_reg;
  assign bit_a     = |(a_reg & bit_mask);
  assign bit_b     = |(b_reg & bit_mask);
  assign work_next = bit_s ? (work_reg | bit_mask) : work_reg;

  fa u_fa (
    .a  (bit_a),
    .b  (bit_b),
    .ci (carry_reg),
    .s  (bit_s),
    .co (bit_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            count_reg <= '0;
            work_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          carry_reg <= bit_co;
          work_reg  <= work_next;
          count_reg <= count_reg + CW'(1);
          // Published result only changes here, so partial sums never reach sum.
          if (count_reg == LAST) begin
            sum_reg   <= work_next;
            cout_reg  <= bit_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg   <= carry_reg ^ bit_co;
`endif
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1; ovf is checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start8 = 1'b0;
  logic [W-1:0] a8 = '0;
  logic [W-1:0] b8 = '0;
  logic         cin8 = 1'b0;
  logic         busy8, done8, cout8;
  logic [W-1:0] sum8;
  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         cin1 = 1'b0;
  logic         busy1, done1, cout1;
  logic [0:0]   sum1;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf8, ovf1;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dones8 = 0;
  int dones1 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic exp_t model(input int width, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int due);
    exp_t e;
    longint unsigned t;
    logic sa, sb, ss;
    t = longint'(a) + longint'(b) + longint'(c);
    e.sum  = W'(t & ((64'd1 << width) - 1));
    e.cout = t[width];
    sa = a[width-1];
    sb = b[width-1];
    ss = e.sum[width-1];
    e.ovf  = (sa == sb) && (ss != sa);
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      exp_t e;
      dones8++;
      if (q8.size() == 0) begin
        chk("spurious_done8", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("latency8", 64'(cyc), 64'(e.due));
        chk("sum8", 64'(sum8), 64'(e.sum));
        chk("cout8", 64'(cout8), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
`endif
        chk("busy_in_done8", 64'(busy8), 64'd0);
        $display("op8 sum=%02h cout=%0d at cycle %0d", sum8, cout8, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1 === 1'b1) begin
      exp_t e;
      dones1++;
      if (q1.size() == 0) begin
        chk("spurious_done1", 64'(done1), 64'd0);
      end else begin
        e = q1.pop_front();
        chk("latency1", 64'(cyc), 64'(e.due));
        chk("sum1", 64'(sum1), 64'(e.sum));
        chk("cout1", 64'(cout1), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf1", 64'(ovf1), 64'(e.ovf));
`endif
        $display("op1 sum=%0d cout=%0d at cycle %0d", sum1, cout1, cyc);
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("timeout8", 64'(done8), 64'd1);
  endtask

  // Called at a negedge with dut8 in IDLE or DONE; returns at the negedge showing done.
  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input int hold, input logic hold_ff);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back(model(W, a, b, c, cyc + 1 + W));
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      a8 = hold_ff ? 8'hFF : W'($urandom);
      b8 = W'($urandom);
      cin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'($urandom);
    wait_done8();
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int n = 0;
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back(model(1, W'(a), W'(b), c, cyc + 2));
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
    while (done1 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("timeout1", 64'(done1), 64'd1);
  endtask

  initial begin
    int k;
    int d0;
    // Reset with start asserted: must stay idle with zeroed outputs.
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; start1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    start8 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    chk("ff_plus_1_sum", 64'(sum8), 64'h00);
    chk("ff_plus_1_cout", 64'(cout8), 64'd1);
    repeat (2) @(negedge clk);

    op8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    chk("7f_plus_1_sum", 64'(sum8), 64'h80);
    op8(8'h80, 8'h80, 1'b0, 0, 1'b0);
    chk("80_plus_80_cout", 64'(cout8), 64'd1);
    repeat (2) @(negedge clk);

    // Start re-asserted with a=FF during RUN must be ignored.
    d0 = dones8;
    op8(8'h12, 8'h34, 1'b1, 5, 1'b1);
    chk("ignore_start_sum", 64'(sum8), 64'h47);
    chk("ignore_start_cout", 64'(cout8), 64'd0);
    repeat (12) @(negedge clk);
    chk("single_done", 64'(dones8 - d0), 64'd1);

    // Start held high: three back-to-back operations, busy low only in DONE.
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) q8.push_back(model(W, 8'h01, 8'h01, 1'b0, k + W + 9 * i));
    for (int r = 0; r < 27; r++) begin
      @(negedge clk);
      if (r == 19) start8 = 1'b0;
      chk("busy_stream", 64'(busy8), 64'((r % 9) != 8));
    end
    repeat (3) @(negedge clk);

    // Reset mid-RUN at count=4 aborts the operation.
    d0 = dones8;
    start8 = 1'b1; a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'b1;
    q8.push_back(model(W, a8, b8, 1'b1, 0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    void'(q8.pop_back());
    @(negedge clk);
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum", 64'(sum8), 64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", 64'(ovf8), 64'd0);
`endif
    chk("abort_no_done", 64'(dones8 - d0), 64'd0);
    rst_n = 1'b1;
    op8(8'h3C, 8'h5A, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Randomized operations with random gaps, including back-to-back from DONE.
    for (int i = 0; i < 30; i++) begin
      op8(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 6)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);

    // WIDTH=1: one RUN cycle.
    op1(1'b1, 1'b1, 1'b1);
    chk("w1_sum", 64'(sum1), 64'd1);
    chk("w1_cout", 64'(cout1), 64'd1);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      op1(bits[0], bits[1], bits[2]);
    end

    repeat (20) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
